// File: rtl/datapath_pipe_if.sv
// datapath_pipe_if
//   Groups the datapath's external signals: the instruction-memory bus, the
//   run control and the observation outputs (register file and flags).
//   Parameters mirror datapath_pipe so widths line up at the instance.
//
//   Signals (direction given for the master = datapath side):
//     run        in   1            1 = advance; 0 = freeze all state
//     ins_addr   out  PC_W         instruction address (the pc, combinational)
//     ins_data   in   INS_W        instruction word for ins_addr, same cycle
//     regs_flat  out  NREG*DATA_W  R[i] at [i*DATA_W +: DATA_W]
//     flag_z     out  1            last ALU/LDI result was zero
//     flag_c     out  1            carry (ADD) / borrow (SUB)
//     halted     out  1            sticky after HALT until reset
//
//   Handshake: there is no valid/ready pair. The instruction bus is a plain
//   combinational read: ins_data must hold the word at ins_addr within the
//   same cycle. run acts as a global enable; while it is low the datapath
//   samples nothing and changes nothing, so the environment may hold or
//   change ins_data freely.
interface datapath_pipe_if #(
  parameter int DATA_W = 4,
  parameter int NREG   = 4,
  parameter int PC_W   = 4
);
  localparam int SW    = $clog2(NREG);
  localparam int PW0   = (2 * SW > DATA_W) ? 2 * SW : DATA_W;
  localparam int PW    = (PW0 > PC_W) ? PW0 : PC_W;
  localparam int INS_W = 3 + SW + PW;

  logic                     run;
  logic [PC_W-1:0]          ins_addr;
  logic [INS_W-1:0]         ins_data;
  logic [NREG*DATA_W-1:0]   regs_flat;
  logic                     flag_z;
  logic                     flag_c;
  logic                     halted;

  modport master (
    input  run,
    input  ins_data,
    output ins_addr,
    output regs_flat,
    output flag_z,
    output flag_c,
    output halted
  );

  modport slave (
    output run,
    output ins_data,
    input  ins_addr,
    input  regs_flat,
    input  flag_z,
    input  flag_c,
    input  halted
  );
endinterface

// File: rtl/datapath_pipe.sv
// datapath_pipe
//   Two-stage CPU datapath: stage 1 fetches ins_data into IR and advances the
//   pc; stage 2 decodes and executes IR, writing back at the closing edge.
//   Because the write lands at the same edge that brings the next instruction
//   into IR, no forwarding or interlock is needed.
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset
//     bus   datapath_pipe_if.master (run, ins_addr/ins_data, regs_flat,
//           flag_z, flag_c, halted)
//
//   Instruction word: op[2:0] | W[SW-1:0] | payload[PW-1:0]
//     A = payload top SW bits, B = next SW bits,
//     IMM = payload[DATA_W-1:0], TGT = payload[PC_W-1:0]
//   Ops: ADD SUB AND OR LDI JMP BZ HALT (000..111)
//
//   Configuration macro: DATAPATH_SAT_EN
//     defined   -> ADD saturates to all-ones on carry, SUB to zero on borrow
//     undefined -> ADD/SUB wrap modulo 2**DATA_W
module datapath_pipe #(
  parameter int DATA_W = 4,
  parameter int NREG   = 4,
  parameter int PC_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  datapath_pipe_if.master   bus
);
  localparam int SW    = $clog2(NREG);
  localparam int PW0   = (2 * SW > DATA_W) ? 2 * SW : DATA_W;
  localparam int PW    = (PW0 > PC_W) ? PW0 : PC_W;
  localparam int INS_W = 3 + SW + PW;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_LDI  = 3'b100,
    OP_JMP  = 3'b101,
    OP_BZ   = 3'b110,
    OP_HALT = 3'b111
  } opcode_t;

  // architectural state
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INS_W-1:0]  ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              halted_q, halted_d;
  logic              flag_z_q, flag_z_d;
  logic              flag_c_q, flag_c_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  // decoded fields of IR
  opcode_t           op;
  logic [SW-1:0]     f_w;
  logic [PW-1:0]     f_p;
  logic [SW-1:0]     f_a;
  logic [SW-1:0]     f_b;
  logic [DATA_W-1:0] f_imm;
  logic [PC_W-1:0]   f_tgt;

  assign op    = opcode_t'(ir_q[INS_W-1 -: 3]);
  assign f_w   = ir_q[INS_W-4 -: SW];
  assign f_p   = ir_q[PW-1:0];
  assign f_a   = f_p[PW-1 -: SW];
  assign f_b   = f_p[PW-1-SW -: SW];
  assign f_imm = f_p[DATA_W-1:0];
  assign f_tgt = f_p[PC_W-1:0];

  // execute-stage results
  logic [DATA_W-1:0] rd_a, rd_b;
  logic [DATA_W:0]   sum, diff;
  logic [DATA_W-1:0] res;
  logic              wr_en, upd_c, c_new, taken, halt_ex;

  assign rd_a = regs_q[f_a];
  assign rd_b = regs_q[f_b];
  assign sum  = {1'b0, rd_a} + {1'b0, rd_b};
  // MSB of the extended difference is set exactly when rd_a < rd_b
  assign diff = {1'b0, rd_a} - {1'b0, rd_b};

  always_comb begin
    res     = '0;
    wr_en   = 1'b0;
    upd_c   = 1'b0;
    c_new   = 1'b0;
    taken   = 1'b0;
    halt_ex = 1'b0;
    if (ir_valid_q) begin
      case (op)
        OP_ADD: begin
          wr_en = 1'b1;
          upd_c = 1'b1;
          c_new = sum[DATA_W];
`ifdef DATAPATH_SAT_EN
          res   = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
`else
          res   = sum[DATA_W-1:0];
`endif
        end
        OP_SUB: begin
          wr_en = 1'b1;
          upd_c = 1'b1;
          c_new = diff[DATA_W];
`ifdef DATAPATH_SAT_EN
          res   = diff[DATA_W] ? {DATA_W{1'b0}} : diff[DATA_W-1:0];
`else
          res   = diff[DATA_W-1:0];
`endif
        end
        OP_AND: begin
          wr_en = 1'b1;
          res   = rd_a & rd_b;
        end
        OP_OR: begin
          wr_en = 1'b1;
          res   = rd_a | rd_b;
        end
        OP_LDI: begin
          wr_en = 1'b1;
          res   = f_imm;
        end
        OP_JMP:  taken = 1'b1;
        OP_BZ:   taken = (rd_a == '0);
        OP_HALT: halt_ex = 1'b1;
      endcase
    end
  end

  // next-state: everything holds unless running and not halted
  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    halted_d   = halted_q;
    flag_z_d   = flag_z_q;
    flag_c_d   = flag_c_q;
    regs_d     = regs_q;
    if (bus.run && !halted_q) begin
      if (wr_en) begin
        regs_d[f_w] = res;
        flag_z_d    = (res == '0);
      end
      if (upd_c) begin
        flag_c_d = c_new;
      end
      if (halt_ex) begin
        // pc already points past HALT; keep it there and drop the fetch
        halted_d   = 1'b1;
        ir_valid_d = 1'b0;
      end else if (taken) begin
        // the word fetched alongside a taken branch is squashed
        pc_d       = f_tgt;
        ir_d       = bus.ins_data;
        ir_valid_d = 1'b0;
      end else begin
        pc_d       = pc_q + PC_W'(1);
        ir_d       = bus.ins_data;
        ir_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
      flag_z_q   <= 1'b0;
      flag_c_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
      flag_z_q   <= flag_z_d;
      flag_c_q   <= flag_c_d;
      regs_q     <= regs_d;
    end
  end

  assign bus.ins_addr = pc_q;
  assign bus.flag_z   = flag_z_q;
  assign bus.flag_c   = flag_c_q;
  assign bus.halted   = halted_q;

  for (genvar gi = 0; gi < NREG; gi++) begin : g_regs_flat
    assign bus.regs_flat[gi*DATA_W +: DATA_W] = regs_q[gi];
  end
endmodule

// File: tb/tb_datapath_pipe.sv
// tb_datapath_pipe
//   Bench for datapath_pipe at default parameters (DATA_W=4, NREG=4, PC_W=4,
//   9-bit instructions). Instruction memory is a local array read
//   combinationally. Contains an ALU vector table, hand sequences for
//   latency/stall/branch/reset/wrap, and random programs compared against an
//   instruction-level interpreter.
module tb_datapath_pipe;
  localparam int OP_ADD = 0, OP_SUB = 1, OP_AND = 2, OP_OR = 3;
  localparam int OP_LDI = 4, OP_JMP = 5, OP_BZ = 6, OP_HALT = 7;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic run = 1'b1;
  logic [8:0] imem [16];

  int total = 0;
  int bad   = 0;

  // interpreter results
  int m_r [4];
  int m_z, m_c, m_pc;

  datapath_pipe_if #(.DATA_W(4), .NREG(4), .PC_W(4)) bus ();

  assign bus.run      = run;
  assign bus.ins_data = imem[bus.ins_addr];

  datapath_pipe #(.DATA_W(4), .NREG(4), .PC_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    run = 1'b1;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // one active edge, sampled 1 time unit later
  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // driver helpers
  function automatic logic [8:0] enc(int op, int w, int p);
    return {3'(op), 2'(w), 4'(p)};
  endfunction

  function automatic logic [8:0] enc3(int op, int w, int a, int b);
    return {3'(op), 2'(w), 2'(a), 2'(b)};
  endfunction

  task automatic fill_halt();
    for (int i = 0; i < 16; i++) imem[i] = enc(OP_HALT, 0, 0);
  endtask

  function automatic int rd(int i);
    return int'(bus.regs_flat[i*4 +: 4]);
  endfunction

  // scoreboard check
  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic run_to_halt(int budget, output int cyc);
    cyc = 0;
    while (!bus.halted && cyc < budget) begin
      step(1);
      cyc++;
    end
    chk("halt_reached", int'(bus.halted), 1);
  endtask

  // instruction-level reference: executes the program in program order
  task automatic model_run();
    int pc, nxt, op, w, p, ra, rb, res;
    bit done;
    logic [8:0] ins;
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_z = 0; m_c = 0;
    pc = 0; done = 0;
    for (int s = 0; s < 40 && !done; s++) begin
      ins = imem[pc];
      op  = int'(ins[8:6]);
      w   = int'(ins[5:4]);
      p   = int'(ins[3:0]);
      ra  = m_r[p / 4];
      rb  = m_r[p % 4];
      nxt = (pc + 1) % 16;
      res = 0;
      case (op)
        OP_ADD: begin
          res = ra + rb;
          m_c = (res > 15) ? 1 : 0;
`ifdef DATAPATH_SAT_EN
          if (res > 15) res = 15;
`else
          res = res % 16;
`endif
        end
        OP_SUB: begin
          res = ra - rb;
          m_c = (ra < rb) ? 1 : 0;
`ifdef DATAPATH_SAT_EN
          if (res < 0) res = 0;
`else
          if (res < 0) res = res + 16;
`endif
        end
        OP_AND: res = ra & rb;
        OP_OR:  res = ra | rb;
        OP_LDI: res = p;
        OP_JMP: nxt = p;
        OP_BZ:  if (ra == 0) nxt = p;
        default: done = 1;
      endcase
      if (op <= OP_LDI) begin
        m_r[w] = res;
        m_z = (res == 0) ? 1 : 0;
      end
      pc = nxt;
    end
    m_pc = pc;
  endtask

  typedef struct {
    int op;
    int a;
    int b;
    int r_wrap;
    int z_wrap;
    int r_sat;
    int z_sat;
    int c;
  } vec_t;

  vec_t vecs [10];

  // JMP 9 / BZ 9 (BZ tests R2, which stays 0) from address 2
  task automatic jump_test(bit is_bz);
    int cyc;
    string tag;
    tag = is_bz ? "bz" : "jmp";
    fill_halt();
    imem[0]  = enc(OP_LDI, 1, 1);
    imem[1]  = is_bz ? enc(OP_LDI, 0, 2) : enc(OP_LDI, 2, 2);
    imem[2]  = is_bz ? enc(OP_BZ, 0, 9) : enc(OP_JMP, 0, 9);
    imem[3]  = enc(OP_LDI, 3, 7);
    imem[9]  = enc(OP_LDI, 0, 4);
    imem[10] = enc(OP_HALT, 0, 0);
    do_reset();
    step(3);
    chk({tag, "_addr_e3"}, int'(bus.ins_addr), 3);
    step(1);
    chk({tag, "_addr_e4"}, int'(bus.ins_addr), 9);
    run_to_halt(20, cyc);
    chk({tag, "_cycles"}, cyc, 3);
    chk({tag, "_r3_squashed"}, rd(3), 0);
    chk({tag, "_r0"}, rd(0), 4);
    chk({tag, "_final_pc"}, int'(bus.ins_addr), 11);
  endtask

  initial begin
    int cyc, op, w, p;

    vecs[0] = '{OP_ADD,  5,  3,  8, 0,  8, 0, 0};
    vecs[1] = '{OP_ADD, 15,  2,  1, 0, 15, 0, 1};
    vecs[2] = '{OP_ADD,  8,  8,  0, 1, 15, 0, 1};
    vecs[3] = '{OP_SUB,  2, 15,  3, 0,  0, 1, 1};
    vecs[4] = '{OP_SUB,  7,  7,  0, 1,  0, 1, 0};
    vecs[5] = '{OP_SUB,  9,  4,  5, 0,  5, 0, 0};
    vecs[6] = '{OP_AND, 12, 10,  8, 0,  8, 0, 0};
    vecs[7] = '{OP_AND,  5, 10,  0, 1,  0, 1, 0};
    vecs[8] = '{OP_OR,   5, 10, 15, 0, 15, 0, 0};
    vecs[9] = '{OP_OR,   0,  0,  0, 1,  0, 1, 0};

    // reset values
    fill_halt();
    do_reset();
    chk("rst_regs", int'(bus.regs_flat), 0);
    chk("rst_addr", int'(bus.ins_addr), 0);
    chk("rst_halted", int'(bus.halted), 0);

    // ALU vector table
    for (int v = 0; v < 10; v++) begin
      fill_halt();
      imem[0] = enc(OP_LDI, 1, vecs[v].a);
      imem[1] = enc(OP_LDI, 2, vecs[v].b);
      imem[2] = enc3(vecs[v].op, 3, 1, 2);
      do_reset();
      run_to_halt(20, cyc);
`ifdef DATAPATH_SAT_EN
      chk($sformatf("vec%0d_r3", v), rd(3), vecs[v].r_sat);
      chk($sformatf("vec%0d_z", v), int'(bus.flag_z), vecs[v].z_sat);
`else
      chk($sformatf("vec%0d_r3", v), rd(3), vecs[v].r_wrap);
      chk($sformatf("vec%0d_z", v), int'(bus.flag_z), vecs[v].z_wrap);
`endif
      chk($sformatf("vec%0d_c", v), int'(bus.flag_c), vecs[v].c);
      chk($sformatf("vec%0d_pc", v), int'(bus.ins_addr), 4);
    end

    // latency, stall and halt freeze
    fill_halt();
    imem[0] = enc(OP_LDI, 1, 5);
    imem[1] = enc(OP_LDI, 2, 3);
    imem[2] = enc3(OP_ADD, 3, 1, 2);
    do_reset();
    step(2);
    chk("lat_r1_e2", rd(1), 5);
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("stall_r1", rd(1), 5);
      chk("stall_r2", rd(2), 0);
      chk("stall_addr", int'(bus.ins_addr), 2);
    end
    run = 1'b1;
    step(1);
    chk("lat_r2_e3", rd(2), 3);
    chk("lat_r3_e3", rd(3), 0);
    step(1);
    chk("lat_r3_e4", rd(3), 8);
    chk("lat_z", int'(bus.flag_z), 0);
    chk("lat_c", int'(bus.flag_c), 0);
    step(1);
    chk("halt_set", int'(bus.halted), 1);
    chk("halt_addr", int'(bus.ins_addr), 4);
    step(5);
    chk("halt_hold_addr", int'(bus.ins_addr), 4);
    chk("halt_hold_r3", rd(3), 8);
    chk("halt_hold_flag", int'(bus.halted), 1);

    // taken JMP / BZ
    jump_test(1'b0);
    jump_test(1'b1);

    // not-taken BZ (TGT 5 -> tests R1, which is 1): no bubble
    fill_halt();
    imem[0] = enc(OP_LDI, 1, 1);
    imem[1] = enc(OP_LDI, 0, 2);
    imem[2] = enc(OP_BZ, 0, 5);
    imem[3] = enc(OP_LDI, 3, 7);
    imem[5] = enc(OP_LDI, 2, 9);
    do_reset();
    run_to_halt(20, cyc);
    chk("bznt_cycles", cyc, 6);
    chk("bznt_r3", rd(3), 7);
    chk("bznt_r2", rd(2), 0);
    chk("bznt_pc", int'(bus.ins_addr), 5);

    // asynchronous reset after carry and halt
    fill_halt();
    imem[0] = enc(OP_LDI, 1, 15);
    imem[1] = enc(OP_LDI, 2, 2);
    imem[2] = enc3(OP_ADD, 0, 1, 2);
    do_reset();
    step(5);
`ifdef DATAPATH_SAT_EN
    chk("carry_r0", rd(0), 15);
`else
    chk("carry_r0", rd(0), 1);
`endif
    chk("carry_c", int'(bus.flag_c), 1);
    chk("pre_rst_halted", int'(bus.halted), 1);
    rst = 1'b1;
    #1;
    chk("arst_regs", int'(bus.regs_flat), 0);
    chk("arst_addr", int'(bus.ins_addr), 0);
    chk("arst_z", int'(bus.flag_z), 0);
    chk("arst_c", int'(bus.flag_c), 0);
    chk("arst_halted", int'(bus.halted), 0);
    rst = 1'b0;

    // pc wraps modulo 16
    for (int i = 0; i < 16; i++) imem[i] = enc(OP_LDI, 0, i);
    do_reset();
    step(15);
    chk("wrap_addr15", int'(bus.ins_addr), 15);
    step(1);
    chk("wrap_addr0", int'(bus.ins_addr), 0);
    chk("wrap_r0", rd(0), 14);

    // random forward-branching programs with random run stalls
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < 15; k++) begin
        op = $urandom_range(0, 7);
        if (op == OP_HALT && $urandom_range(0, 3) != 0) op = OP_LDI;
        if (op == OP_JMP || op == OP_BZ) p = $urandom_range(k + 1, 15);
        else p = $urandom_range(0, 15);
        w = $urandom_range(0, 3);
        imem[k] = enc(op, w, p);
      end
      imem[15] = enc(OP_HALT, 0, 0);
      model_run();
      do_reset();
      cyc = 0;
      while (!bus.halted && cyc < 300) begin
        run = ($urandom_range(0, 3) != 0);
        step(1);
        cyc++;
      end
      run = 1'b1;
      chk("rnd_halted", int'(bus.halted), 1);
      for (int i = 0; i < 4; i++) chk($sformatf("rnd%0d_r%0d", t, i), rd(i), m_r[i]);
      chk($sformatf("rnd%0d_z", t), int'(bus.flag_z), m_z);
      chk($sformatf("rnd%0d_c", t), int'(bus.flag_c), m_c);
      chk($sformatf("rnd%0d_pc", t), int'(bus.ins_addr), m_pc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
